db15_serial_joy: RTL

- Serial front end for the DB15 UserIO joystick adapter: a 74HC165-style shift chain carrying both players' buttons.
- Drives the adapter's load and clock lines and samples its data line.
- Presents two debounced-or-raw, active-high 16-bit joystick words to the core's joystick mux.
- Sits directly upstream of the console's joystick/keypad logic; runs on the 40-50 MHz joystick clock.

---
 rtl/db15_serial_joy.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/db15_serial_joy.sv
// ---------------------------------------------------------------------------
// db15_serial_joy
//
// Serial front end for the DB15 UserIO joystick adapter. The adapter is a
// 74HC165-style parallel-in/serial-out chain that carries both players'
// buttons in one 32-bit frame. This block pulses the chain's load line,
// clocks the 32 bits out and presents two active-high 16-bit joystick words.
//
// Ports:
//   clk          joystick clock (40-50 MHz)
//   reset        synchronous, active-high reset
//   joy_data     serial data from the adapter (active-low buttons, idles high)
//   joy_clk      shift clock to the adapter (chain shifts on its rising edge)
//   joy_load     parallel load to the adapter, active low
//   joystick1    player 1 buttons, active high (frame bits 15:0)
//   joystick2    player 2 buttons, active high (frame bits 31:16)
//   frame_strobe one-clk pulse per completed frame
//   busy         high from load entry through the frame-complete cycle
//
// Parameters:
//   CLK_DIV      clk cycles per shift tick (>= 2)
//   POLL_TICKS   idle ticks between the end of a frame and the next load (>= 1)
//
// Optional feature (macro DB15_JOY_DEBOUNCE_EN):
//   When defined, the joystick words only update when two consecutive frames
//   are identical, rejecting single-frame glitches at the cost of one frame
//   of latency. frame_strobe still pulses every frame.
// ---------------------------------------------------------------------------
module db15_serial_joy #(
  parameter int unsigned CLK_DIV    = 24,
  parameter int unsigned POLL_TICKS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_strobe,
  output logic        busy
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned POLL_W = $clog2(POLL_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_TICKS - 1);
  localparam logic [POLL_W-1:0] POLL_ONE  = POLL_W'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_HIGH   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]        state;
  logic [DIV_W-1:0]  div;
  logic [POLL_W-1:0] poll_cnt;
  logic [4:0]        idx;
  logic [31:0]       shreg;
  logic              tick;

`ifdef DB15_JOY_DEBOUNCE_EN
  logic [31:0]       prev;
`endif

  // Free-running shift-tick divider: one tick every CLK_DIV clks.
  always_comb begin
    tick = (div == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div          <= '0;
      state        <= ST_IDLE;
      // Preloaded one short of the limit so the first tick after reset
      // starts a frame without waiting a full poll interval.
      poll_cnt     <= POLL_LAST;
      idx          <= '0;
      shreg        <= '0;
      joy_clk      <= 1'b0;
      joy_load     <= 1'b1;
      joystick1    <= '0;
      joystick2    <= '0;
      frame_strobe <= 1'b0;
      busy         <= 1'b0;
    end else begin
      div          <= tick ? '0 : div + DIV_W'(1);
      frame_strobe <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (tick) begin
            poll_cnt <= poll_cnt + POLL_ONE;
            if (poll_cnt == POLL_LAST) begin
              state    <= ST_LOAD;
              joy_load <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          // joy_load stays low for one full tick interval.
          if (tick) begin
            joy_load <= 1'b1;
            idx      <= '0;
            state    <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          // Wire is active low; store buttons active high.
          if (tick) begin
            shreg[idx] <= ~joy_data;
            if (idx == 5'd31) begin
              state <= ST_DONE;
            end else begin
              joy_clk <= 1'b1;
              state   <= ST_HIGH;
            end
          end
        end

        ST_HIGH: begin
          // Falling edge here; the next bit is sampled one tick later so the
          // adapter output has a whole tick to settle.
          if (tick) begin
            joy_clk <= 1'b0;
            idx     <= idx + 5'd1;
            state   <= ST_SAMPLE;
          end
        end

        ST_DONE: begin
`ifdef DB15_JOY_DEBOUNCE_EN
          if (shreg == prev) begin
            joystick1 <= shreg[15:0];
            joystick2 <= shreg[31:16];
          end
`else
          joystick1 <= shreg[15:0];
          joystick2 <= shreg[31:16];
`endif
          frame_strobe <= 1'b1;
          busy         <= 1'b0;
          poll_cnt     <= '0;
          state        <= ST_IDLE;
        end

        default: begin
          state    <= ST_IDLE;
          joy_clk  <= 1'b0;
          joy_load <= 1'b1;
          busy     <= 1'b0;
          poll_cnt <= '0;
        end
      endcase
    end
  end

`ifdef DB15_JOY_DEBOUNCE_EN
  // Last captured frame, compared against the new one in the done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
    end else if (state == ST_DONE) begin
      prev <= shreg;
    end
  end
`endif

endmodule
